// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - shared types and widths for the approximate adder arbiter
package approx_adder_pkg;
   localparam int OP_W      = 8;
   localparam int SUM_W     = 9;
   localparam int N_APPROX  = 3;
   localparam int N_REQ_DEF = 4;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/approx_adder_arbiter_adder.sv
// rtl/approx_adder_arbiter_adder.sv - 8-bit ripple adder with N_APPROX OR-sum LSB cells
module approx_adder
   import approx_adder_pkg::*;
#(
   parameter int N_APPROX_CELLS = N_APPROX
) (
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [SUM_W-1:0] sum
);
   // Approximate cells keep the exact majority carry but replace XOR with OR for the sum bit.
   always_comb begin
      logic carry;
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < OP_W; i++) begin
         if (i < N_APPROX_CELLS) begin
            sum[i] = a[i] | b[i] | carry;
         end else begin
            sum[i] = a[i] ^ b[i] ^ carry;
         end
         carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
      sum[OP_W] = carry;
   end
endmodule

// File: rtl/approx_adder_arbiter_rr.sv
// rtl/approx_adder_arbiter_rr.sv - round-robin grant starting the scan at ptr
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);
   always_comb begin
      int               pos;
      logic [IDX_W-1:0] idx;
      logic             found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         idx = IDX_W'(pos);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
      any_req = found;
   end
endmodule

// File: rtl/approx_adder_arbiter.sv
// rtl/approx_adder_arbiter.sv - one shared approximate adder, round-robin over N_REQ requesters
// Optional error monitor (exact adder, res_err, err_cnt) enabled by APPROX_ERR_MON_EN.
module approx_adder_arbiter
   import approx_adder_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = $clog2(N_REQ)
`ifdef APPROX_ERR_MON_EN
   , parameter int ERR_CW = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [OP_W*N_REQ-1:0] req_a,
   input  logic [OP_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [SUM_W-1:0]      res_sum,
   output logic [ID_W-1:0]       res_id,
   output logic                  busy
`ifdef APPROX_ERR_MON_EN
   , output logic                res_err,
   output logic [ERR_CW-1:0]     err_cnt
`endif
);
   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
   logic [ID_W-1:0]   op_id_q, op_id_d;
   logic              res_valid_q, res_valid_d;
   logic [SUM_W-1:0]  res_sum_q, res_sum_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic              busy_q, busy_d;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_idx;
   logic              any_req;
   logic [OP_W-1:0]   win_a, win_b;
   logic [SUM_W-1:0]  approx_sum;

   rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   approx_adder #(.N_APPROX_CELLS(N_APPROX)) u_approx (
      .a   (op_a_q),
      .b   (op_b_q),
      .sum (approx_sum)
   );

`ifdef APPROX_ERR_MON_EN
   logic              res_err_q, res_err_d;
   logic [ERR_CW-1:0] err_cnt_q, err_cnt_d;
   logic [SUM_W-1:0]  exact_sum;

   approx_adder #(.N_APPROX_CELLS(0)) u_exact (
      .a   (op_a_q),
      .b   (op_b_q),
      .sum (exact_sum)
   );

   assign res_err = res_err_q;
   assign err_cnt = err_cnt_q;
`endif

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            win_a = win_a | req_a[OP_W*i +: OP_W];
            win_b = win_b | req_b[OP_W*i +: OP_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_id_d    = res_id_q;
`ifdef APPROX_ERR_MON_EN
      res_err_d   = res_err_q;
      err_cnt_d   = err_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d  = EXEC;
               op_a_d   = win_a;
               op_b_d   = win_b;
               op_id_d  = grant_idx;
               rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
         end
         EXEC: begin
            state_d     = RESP;
            res_sum_d   = approx_sum;
            res_id_d    = op_id_q;
            res_valid_d = 1'b1;
`ifdef APPROX_ERR_MON_EN
            res_err_d   = (approx_sum != exact_sum);
`endif
         end
         RESP: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
`ifdef APPROX_ERR_MON_EN
               if (res_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CW'(1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= '0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_id_q    <= '0;
         busy_q      <= 1'b0;
`ifdef APPROX_ERR_MON_EN
         res_err_q   <= 1'b0;
         err_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_id_q    <= res_id_d;
         busy_q      <= busy_d;
`ifdef APPROX_ERR_MON_EN
         res_err_q   <= res_err_d;
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   // Held low while rst_n is asserted so no transfer appears to happen during reset.
   assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_id    = res_id_q;
   assign busy      = busy_q;
endmodule
